// File: rtl/sum_accumulator_if.sv
// -----------------------------------------------------------------------------
// sum_accumulator_if
//   Handshake bundle for the sum_accumulator stage.
//   Input side:  in_valid / in_ready / in_sum (5-bit adder sum, carry in bit 4).
//   Output side: out_valid / out_ready / out_acc / out_ovf.
//   Side band:   clear (synchronous abort) and busy (batch in progress).
//   ACC_W must match the ACC_W of the sum_accumulator instance it connects to.
// -----------------------------------------------------------------------------
interface sum_accumulator_if #(
  parameter int ACC_W = 8
) ();

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;
  logic             busy;

  // Producer / consumer side: drives samples, accepts results.
  modport master (
    output clear,
    output in_valid,
    output in_sum,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_acc,
    input  out_ovf,
    input  busy
  );

  // Accumulator side.
  modport slave (
    input  clear,
    input  in_valid,
    input  in_sum,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_acc,
    output out_ovf,
    output busy
  );

endinterface

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
//   Sequential consumer of the 4-bit ripple adder's 5-bit sum. Accepts COUNT
//   samples over valid/ready, accumulates them into an ACC_W-bit register and
//   then holds the total on the output handshake until it is taken.
//
//   Two states:
//     ACC  - in_ready=1, samples are accumulated.
//     HOLD - in_ready=0, out_valid=1, result stable until out_ready.
//   Accept and result release never share a cycle, so a result costs at
//   least COUNT+1 cycles. in_ready depends on state only.
//
//   clear is a synchronous abort with highest priority: it drops a partial
//   batch or a held result and suppresses any accept in the same cycle.
//
//   Optional build macro: SUM_ACC_SATURATE_EN
//     defined   - on carry out of bit ACC_W-1 the accumulator pins to
//                 2^ACC_W-1 for the rest of the batch.
//     undefined - (default) the accumulator wraps modulo 2^ACC_W.
//   In both builds out_ovf records that the batch total exceeded ACC_W bits.
//
//   Parameter constraints: ACC_W >= 5, COUNT >= 1.
// -----------------------------------------------------------------------------
module sum_accumulator #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_accumulator_if.slave   bus
);

  // COUNT=1 still gets a 1-bit counter that simply never leaves zero.
  localparam int                CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COUNT - 1);
  localparam int                SUM_W    = ACC_W + 1;

  // Legacy-compatible state encoding.
  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state, state_next;
  logic [ACC_W-1:0] acc,   acc_next;
  logic [CNT_W-1:0] cnt,   cnt_next;
  logic             ovf,   ovf_next;

  logic             accept;
  logic             res_take;
  logic [SUM_W-1:0] sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;

  // ---------------------------------------------------------------------------
  // Handshake outputs: all derived from registered state, no input feedthrough.
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_acc   = (state == ST_HOLD) ? acc : '0;
  assign bus.out_ovf   = (state == ST_HOLD) & ovf;
  assign bus.busy      = (state == ST_ACC) && (cnt != '0);

  // clear masks both sides of the handshake so an abort never consumes data.
  assign accept   = bus.in_valid  && (state == ST_ACC)  && !bus.clear;
  assign res_take = bus.out_ready && (state == ST_HOLD) && !bus.clear;

  // One extra bit catches the carry out of the accumulator's MSB.
  assign sum_ext = {1'b0, acc} + SUM_W'(bus.in_sum);
  assign carry   = sum_ext[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = '1;
  // Once the batch has overflowed the total stays pinned at full scale.
  assign acc_add = (carry || ovf) ? ACC_MAX : sum_ext[ACC_W-1:0];
`else
  // Plain modulo-2^ACC_W wrap; ovf remembers that a wrap happened.
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  // Next-state logic for the FSM, accumulator, sample counter and ovf flag.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    ovf_next   = ovf;

    if (bus.clear) begin
      state_next = ST_ACC;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            acc_next = acc_add;
            ovf_next = ovf | carry;
            if (cnt == CNT_LAST) begin
              state_next = ST_HOLD;
              cnt_next   = '0;
            end else begin
              cnt_next   = cnt + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (res_take) begin
            state_next = ST_ACC;
            acc_next   = '0;
            ovf_next   = 1'b0;
          end
        end
        default: begin
          state_next = ST_ACC;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; every register here is small and reset, so
    // reset gives a fully defined restart even mid-batch or mid-HOLD.
    if (!rst_n) begin
      state <= ST_ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
      ovf   <= ovf_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties (ignored by synthesis).
  // ---------------------------------------------------------------------------
  // The two sides of the stage are never open at the same time.
  a_no_bypass : assert property (@(posedge clk) disable iff (!rst_n)
    bus.in_ready != bus.out_valid);

  // A held result does not change until it is taken or aborted.
  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready && !bus.clear)
      |=> (bus.out_valid && $stable(bus.out_acc) && $stable(bus.out_ovf)));

  // The sample counter never runs past the last sample of a batch.
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    cnt <= CNT_LAST);

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
//   Three instances: A (ACC_W=8, COUNT=4), B (ACC_W=6, COUNT=5) for overflow,
//   C (ACC_W=8, COUNT=1). Instance A is checked against a reference model
//   whose results go through a scoreboard queue; B and C use hand sequences.
//   Inputs are driven and outputs sampled 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sum_accumulator_if #(.ACC_W(8)) ia ();
  sum_accumulator_if #(.ACC_W(6)) ib ();
  sum_accumulator_if #(.ACC_W(8)) ic ();

  sum_accumulator #(.ACC_W(8), .COUNT(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  sum_accumulator #(.ACC_W(6), .COUNT(5)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
  sum_accumulator #(.ACC_W(8), .COUNT(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));

`ifdef SUM_ACC_SATURATE_EN
  localparam int B_OVF_ACC = 63;
`else
  localparam int B_OVF_ACC = 27;
`endif

  typedef struct {
    logic [7:0] acc;
    logic       ovf;
  } res_t;

  typedef struct {
    logic [3:0][4:0] s;        // s[0] is driven first
    logic            gap;      // idle cycle (in_sum=X) between samples
    logic [7:0]      exp_acc;
  } vec_t;

  res_t sb[$];
  vec_t tbl[5];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of instance A.
  logic [7:0] m_acc  = '0;
  logic       m_ovf  = 1'b0;
  logic       m_hold = 1'b0;
  int         m_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] c, input logic [4:0] d,
                              input logic gap, input logic [7:0] exp_acc);
    vec_t v;
    v.s       = {d, c, b, a};
    v.gap     = gap;
    v.exp_acc = exp_acc;
    return v;
  endfunction

  task automatic model_reset();
    sb.delete();
    m_acc  = '0;
    m_ovf  = 1'b0;
    m_hold = 1'b0;
    m_cnt  = 0;
  endtask

  // Advance one clock; the model of A consumes the inputs present at the edge.
  task automatic cycle();
    res_t       e;
    logic [8:0] sum9;
    check("a_out_valid_vs_model", 32'(ia.out_valid), 32'(m_hold));
    if (ia.clear) begin
      if (m_hold && sb.size() != 0) e = sb.pop_front();
      m_acc  = '0;
      m_ovf  = 1'b0;
      m_hold = 1'b0;
      m_cnt  = 0;
    end else if (m_hold) begin
      if (ia.out_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_out_acc", 32'(ia.out_acc), 32'(e.acc));
          check("sb_out_ovf", 32'(ia.out_ovf), 32'(e.ovf));
        end
        m_hold = 1'b0;
        m_acc  = '0;
        m_ovf  = 1'b0;
      end
    end else if (ia.in_valid) begin
      sum9 = {1'b0, m_acc} + {4'b0, ia.in_sum};
`ifdef SUM_ACC_SATURATE_EN
      m_acc = (sum9[8] || m_ovf) ? 8'hFF : sum9[7:0];
`else
      m_acc = sum9[7:0];
`endif
      m_ovf = m_ovf | sum9[8];
      m_cnt++;
      if (m_cnt == 4) begin
        e.acc = m_acc;
        e.ovf = m_ovf;
        sb.push_back(e);
        m_hold = 1'b1;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_a_valid(input int max_cycles);
    int n = 0;
    while (!ia.out_valid && n < max_cycles) begin
      cycle();
      n++;
    end
    check("a_wait_out_valid", 32'(ia.out_valid), 1);
  endtask

  // Drive one full batch into A with out_ready=1 and check the result.
  task automatic run_batch(input vec_t v);
    ia.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v.gap && i > 0) begin
        ia.in_valid = 1'b0;
        ia.in_sum   = 'x;
        cycle();
      end
      ia.in_valid = 1'b1;
      ia.in_sum   = v.s[i];
      cycle();
      if (i == 0) check("a_busy_after_first", 32'(ia.busy), 1);
    end
    ia.in_valid = 1'b0;
    ia.in_sum   = 'x;
    wait_a_valid(4);
    check("a_batch_out_acc", 32'(ia.out_acc), 32'(v.exp_acc));
    check("a_batch_out_ovf", 32'(ia.out_ovf), 0);
    check("a_hold_in_ready", 32'(ia.in_ready), 0);
    check("a_hold_busy", 32'(ia.busy), 0);
    cycle();
    check("a_released", 32'(ia.out_valid), 0);
  endtask

  task automatic feed_a(input logic [4:0] v);
    ia.in_valid = 1'b1;
    ia.in_sum   = v;
    cycle();
    ia.in_valid = 1'b0;
  endtask

  task automatic feed_b(input logic [4:0] v);
    ib.in_valid = 1'b1;
    ib.in_sum   = v;
    cycle();
    ib.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(5'd3,  5'd5,  5'd7,  5'd9,  1'b0, 8'd24);
    tbl[1] = mk(5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 8'd0);
    tbl[2] = mk(5'd31, 5'd31, 5'd31, 5'd31, 1'b1, 8'd124);
    tbl[3] = mk(5'd1,  5'd2,  5'd4,  5'd8,  1'b1, 8'd15);
    tbl[4] = mk(5'd16, 5'd0,  5'd31, 5'd1,  1'b0, 8'd48);

    ia.clear = 1'b0; ia.in_valid = 1'b0; ia.in_sum = '0; ia.out_ready = 1'b0;
    ib.clear = 1'b0; ib.in_valid = 1'b0; ib.in_sum = '0; ib.out_ready = 1'b0;
    ic.clear = 1'b0; ic.in_valid = 1'b0; ic.in_sum = '0; ic.out_ready = 1'b0;

    // Reset values.
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready",  32'(ia.in_ready), 1);
    check("rst_out_valid", 32'(ia.out_valid), 0);
    check("rst_out_acc",   32'(ia.out_acc), 0);
    check("rst_out_ovf",   32'(ia.out_ovf), 0);
    check("rst_busy",      32'(ia.busy), 0);
    check("rst_b_in_ready", 32'(ib.in_ready), 1);
    check("rst_c_out_valid", 32'(ic.out_valid), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven batches (first entry: 3,5,7,9 -> 24).
    for (int i = 0; i < 5; i++) run_batch(tbl[i]);

    // Backpressure: hold for 5 cycles with samples offered, then release.
    ia.out_ready = 1'b0;
    feed_a(5'd1); feed_a(5'd2); feed_a(5'd3); feed_a(5'd4);
    ia.in_valid = 1'b1;
    ia.in_sum   = 5'd9;
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", 32'(ia.out_valid), 1);
      check("bp_out_acc",   32'(ia.out_acc), 10);
      check("bp_in_ready",  32'(ia.in_ready), 0);
      cycle();
    end
    check("bp_out_acc_end", 32'(ia.out_acc), 10);
    ia.out_ready = 1'b1;
    cycle();
    check("bp_after_release_busy", 32'(ia.busy), 0);
    check("bp_after_release_in_ready", 32'(ia.in_ready), 1);
    ia.in_valid = 1'b0;
    run_batch(mk(5'd2, 5'd2, 5'd2, 5'd2, 1'b0, 8'd8));

    // clear after two samples, with a sample offered in the clear cycle.
    feed_a(5'd5); feed_a(5'd6);
    check("clr_busy_before", 32'(ia.busy), 1);
    ia.in_valid = 1'b1;
    ia.in_sum   = 5'd7;
    ia.clear    = 1'b1;
    cycle();
    ia.clear    = 1'b0;
    ia.in_valid = 1'b0;
    check("clr_busy_after",  32'(ia.busy), 0);
    check("clr_out_valid",   32'(ia.out_valid), 0);
    run_batch(mk(5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 8'd4));

    // clear in HOLD discards the result even with out_ready=1.
    ia.out_ready = 1'b0;
    feed_a(5'd10); feed_a(5'd10); feed_a(5'd10); feed_a(5'd10);
    check("clr_hold_out_acc", 32'(ia.out_acc), 40);
    ia.clear     = 1'b1;
    ia.out_ready = 1'b1;
    cycle();
    ia.clear = 1'b0;
    check("clr_hold_dropped", 32'(ia.out_valid), 0);
    check("clr_hold_out_acc0", 32'(ia.out_acc), 0);
    run_batch(mk(5'd1, 5'd2, 5'd3, 5'd4, 1'b1, 8'd10));

    // Asynchronous reset pulse between edges while holding a result.
    ia.out_ready = 1'b0;
    feed_a(5'd7); feed_a(5'd7); feed_a(5'd7); feed_a(5'd7);
    check("arst_pre_out_acc", 32'(ia.out_acc), 28);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(ia.out_valid), 0);
    check("arst_out_acc",   32'(ia.out_acc), 0);
    check("arst_in_ready",  32'(ia.in_ready), 1);
    rst_n = 1'b1;
    model_reset();
    run_batch(mk(5'd31, 5'd31, 5'd31, 5'd31, 1'b0, 8'd124));

    // Instance B: ACC_W=6, COUNT=5 -> overflow batch, then exact full scale.
    ib.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) feed_b(5'd31);
    check("b_ovf_out_valid", 32'(ib.out_valid), 1);
    check("b_ovf_out_acc",   32'(ib.out_acc), B_OVF_ACC);
    check("b_ovf_out_ovf",   32'(ib.out_ovf), 1);
    cycle();
    check("b_released", 32'(ib.out_valid), 0);
    feed_b(5'd31); feed_b(5'd31); feed_b(5'd1); feed_b(5'd0); feed_b(5'd0);
    check("b_max_out_acc", 32'(ib.out_acc), 63);
    check("b_max_out_ovf", 32'(ib.out_ovf), 0);
    cycle();

    // Instance C: COUNT=1, one result per two cycles.
    ic.out_ready = 1'b1;
    ic.in_valid  = 1'b1;
    ic.in_sum    = 5'd17;
    cycle();
    check("c_out_valid", 32'(ic.out_valid), 1);
    check("c_out_acc",   32'(ic.out_acc), 17);
    check("c_busy",      32'(ic.busy), 0);
    check("c_in_ready",  32'(ic.in_ready), 0);
    cycle();
    check("c_release_valid", 32'(ic.out_valid), 0);
    check("c_release_ready", 32'(ic.in_ready), 1);
    ic.in_sum = 5'd31;
    cycle();
    ic.in_valid = 1'b0;
    check("c_second_out_acc", 32'(ic.out_acc), 31);
    cycle();
    check("c_idle", 32'(ic.out_valid), 0);

    check("sb_empty_at_end", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
